// File: rtl/reg_bank_if.sv
// Write-back bus between the pipeline and reg_bank: register write ports,
// register read-out, and the interrupt request/acknowledge handshake.
interface reg_bank_if;
   logic [415:0] wdata;
   logic [12:0]  wen;
   logic         irq_in;
   logic [7:0]   irq_num_in;
   logic         irq_ack;
   logic [415:0] rdata;
   logic         irq_pending;
   logic [7:0]   irq_num;
   logic         irq_lost;

   modport master (
      output wdata, wen, irq_in, irq_num_in, irq_ack,
      input  rdata, irq_pending, irq_num, irq_lost
   );

   modport slave (
      input  wdata, wen, irq_in, irq_num_in, irq_ack,
      output rdata, irq_pending, irq_num, irq_lost
   );
endinterface

// File: rtl/reg_bank.sv
// Thirteen-slot architectural register bank with a single-entry interrupt latch.
// Optional macro REG_BANK_WRITE_BYPASS_EN forwards write data to rdata in the same cycle.
module reg_bank #(
   parameter logic [31:0] SP_RESET = 32'h0000_FFFC,
   parameter logic [31:0] CS_RESET = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       rst,
   reg_bank_if.slave  bus
);

   localparam int NSLOTS  = 13;
   localparam int SLOT_CS = 6;
   localparam int SLOT_SP = 11;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } irqState_t;

   logic [31:0]  r_regs [NSLOTS];
   irqState_t    r_state;
   logic         r_irqPending;
   logic [7:0]   r_irqNum;
   logic         r_irqLost;
   logic [415:0] w_rdata;

   // Slots are independent; every enabled slot loads in the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSLOTS; k++) begin
            if (k == SLOT_CS)
               r_regs[k] <= CS_RESET;
            else if (k == SLOT_SP)
               r_regs[k] <= SP_RESET;
            else
               r_regs[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NSLOTS; k++) begin
            if (bus.wen[k])
               r_regs[k] <= bus.wdata[32*k +: 32];
         end
      end
   end

   // A request arriving while one is pending is only accepted if the ack
   // frees the latch in that same cycle; otherwise it is dropped and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_irqPending <= 1'b0;
         r_irqNum     <= 8'h00;
         r_irqLost    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.irq_in) begin
                  r_state      <= PEND;
                  r_irqPending <= 1'b1;
                  r_irqNum     <= bus.irq_num_in;
               end
            end
            PEND: begin
               if (bus.irq_in) begin
                  if (bus.irq_ack)
                     r_irqNum <= bus.irq_num_in;
                  else
                     r_irqLost <= 1'b1;
               end else if (bus.irq_ack) begin
                  r_state      <= IDLE;
                  r_irqPending <= 1'b0;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_irqPending <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_rdata = '0;
      for (int k = 0; k < NSLOTS; k++) begin
`ifdef REG_BANK_WRITE_BYPASS_EN
         w_rdata[32*k +: 32] = bus.wen[k] ? bus.wdata[32*k +: 32] : r_regs[k];
`else
         w_rdata[32*k +: 32] = r_regs[k];
`endif
      end
   end

   assign bus.rdata       = w_rdata;
   assign bus.irq_pending = r_irqPending;
   assign bus.irq_num     = r_irqNum;
   assign bus.irq_lost    = r_irqLost;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: expected snapshots {rdata, irq_pending,
// irq_num, irq_lost} are queued when stimulus is applied and checked after the edge.
module tb_reg_bank;

   typedef logic [425:0] snap_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   reg_bank_if busIf();

   reg_bank dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf)
   );

   int    total = 0;
   int    bad   = 0;
   snap_t sbq[$];

   logic [415:0] expRegs;
   logic         expPend;
   logic [7:0]   expNum;
   logic         expLost;

   // Reset image taken straight from the default parameter values.
   function automatic logic [415:0] resetImage();
      logic [415:0] img;
      img = '0;
      img[6*32 +: 32]  = 32'h0000_0000;
      img[11*32 +: 32] = 32'h0000_FFFC;
      return img;
   endfunction

   task automatic applyStimulus(input logic rstVal, input logic [12:0] wen,
                                input logic [415:0] wdata, input logic irq,
                                input logic [7:0] num, input logic ack);
      rst              = rstVal;
      busIf.wen        = wen;
      busIf.wdata      = wdata;
      busIf.irq_in     = irq;
      busIf.irq_num_in = num;
      busIf.irq_ack    = ack;
   endtask

   task automatic test_reset();
      snap_t e;
      snap_t o;
      @(negedge clk);
      applyStimulus(1'b1, 13'h1FFF, {13{32'h1234_5678}}, 1'b1, 8'h77, 1'b1);
      expRegs = resetImage(); expPend = 1'b0; expNum = 8'h00; expLost = 1'b0;
      sbq.push_back({expRegs, expPend, expNum, expLost});
      @(posedge clk); #1;
      e = sbq.pop_front(); o = {busIf.rdata, busIf.irq_pending, busIf.irq_num, busIf.irq_lost};
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL reset_state: got %h want %h", o, e); end
      @(negedge clk);
      applyStimulus(1'b0, 13'h0000, '0, 1'b0, 8'h00, 1'b0);
      sbq.push_back({expRegs, expPend, expNum, expLost});
      @(posedge clk); #1;
      e = sbq.pop_front(); o = {busIf.rdata, busIf.irq_pending, busIf.irq_num, busIf.irq_lost};
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL reset_hold: got %h want %h", o, e); end
   endtask

   task automatic test_write();
      snap_t        e;
      snap_t        o;
      logic [415:0] wd;
      logic [12:0]  wn;
      for (int row = 0; row < 12; row++) begin
         wd = '0;
         for (int k = 0; k < 13; k++) wd[32*k +: 32] = $urandom;
         if (row == 0) begin
            wn = 13'h0801;
            wd[0 +: 32]     = 32'hDEAD_BEEF;
            wd[11*32 +: 32] = 32'h0000_1000;
         end else if (row == 1) wn = 13'h1FFF;
         else if (row == 11)    wn = 13'h0000;
         else                   wn = 13'($urandom_range(0, 13'h1FFF));
         @(negedge clk);
         applyStimulus(1'b0, wn, wd, 1'b0, 8'h00, 1'b0);
         for (int k = 0; k < 13; k++)
            if (wn[k]) expRegs[32*k +: 32] = wd[32*k +: 32];
`ifdef REG_BANK_WRITE_BYPASS_EN
         #1;
         total++;
         if (busIf.rdata !== expRegs) begin
            bad++; $display("[TB] FAIL write_bypass row%0d: got %h want %h", row, busIf.rdata, expRegs);
         end
`endif
         sbq.push_back({expRegs, expPend, expNum, expLost});
         @(posedge clk); #1;
         e = sbq.pop_front(); o = {busIf.rdata, busIf.irq_pending, busIf.irq_num, busIf.irq_lost};
         total++;
         if (o !== e) begin bad++; $display("[TB] FAIL write row%0d: got %h want %h", row, o, e); end
      end
   endtask

   task automatic test_irq_basic();
      snap_t e;
      snap_t o;
      logic [1:0] irqRow [3];
      logic [1:0] pendRow[3];
      irqRow  = '{2'b10, 2'b01, 2'b01};
      pendRow = '{2'b01, 2'b00, 2'b00};
      for (int row = 0; row < 3; row++) begin
         @(negedge clk);
         applyStimulus(1'b0, 13'h0000, '0, irqRow[row][1], 8'd8, irqRow[row][0]);
         expPend = pendRow[row][0];
         expNum  = 8'd8;
         sbq.push_back({expRegs, expPend, expNum, expLost});
         @(posedge clk); #1;
         e = sbq.pop_front(); o = {busIf.rdata, busIf.irq_pending, busIf.irq_num, busIf.irq_lost};
         total++;
         if (o !== e) begin bad++; $display("[TB] FAIL irq_basic row%0d: got %h want %h", row, o, e); end
      end
   endtask

   task automatic test_irq_lost();
      snap_t e;
      snap_t o;
      logic       irqs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] nums [5] = '{8'd8, 8'd3, 8'd3, 8'd0, 8'd0};
      logic       acks [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       pends[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       losts[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int row = 0; row < 5; row++) begin
         @(negedge clk);
         applyStimulus(1'b0, 13'h0000, '0, irqs[row], nums[row], acks[row]);
         expPend = pends[row]; expNum = 8'd8; expLost = losts[row];
         sbq.push_back({expRegs, expPend, expNum, expLost});
         @(posedge clk); #1;
         e = sbq.pop_front(); o = {busIf.rdata, busIf.irq_pending, busIf.irq_num, busIf.irq_lost};
         total++;
         if (o !== e) begin bad++; $display("[TB] FAIL irq_lost row%0d: got %h want %h", row, o, e); end
      end
   endtask

   task automatic test_handover();
      snap_t e;
      snap_t o;
      logic       rsts [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic       irqs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0] nums [4] = '{8'd0, 8'd8, 8'd5, 8'd0};
      logic       acks [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic       pends[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0] eNums[4] = '{8'd0, 8'd8, 8'd5, 8'd5};
      for (int row = 0; row < 4; row++) begin
         @(negedge clk);
         applyStimulus(rsts[row], 13'h0000, '0, irqs[row], nums[row], acks[row]);
         if (rsts[row]) expRegs = resetImage();
         expPend = pends[row]; expNum = eNums[row]; expLost = 1'b0;
         sbq.push_back({expRegs, expPend, expNum, expLost});
         @(posedge clk); #1;
         e = sbq.pop_front(); o = {busIf.rdata, busIf.irq_pending, busIf.irq_num, busIf.irq_lost};
         total++;
         if (o !== e) begin bad++; $display("[TB] FAIL handover row%0d: got %h want %h", row, o, e); end
      end
   endtask

   task automatic test_concurrent();
      snap_t        e;
      snap_t        o;
      logic [415:0] wd;
      wd = '0;
      wd[3*32 +: 32] = 32'hCAFE_F00D;
      @(negedge clk);
      applyStimulus(1'b0, 13'h0008, wd, 1'b1, 8'h42, 1'b0);
      expRegs[3*32 +: 32] = 32'hCAFE_F00D;
      expPend = 1'b1; expNum = 8'h42; expLost = 1'b0;
      sbq.push_back({expRegs, expPend, expNum, expLost});
      @(posedge clk); #1;
      e = sbq.pop_front(); o = {busIf.rdata, busIf.irq_pending, busIf.irq_num, busIf.irq_lost};
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL concurrent: got %h want %h", o, e); end
   endtask

   task automatic test_reset_mid();
      snap_t e;
      snap_t o;
      @(negedge clk);
      applyStimulus(1'b1, 13'h1FFF, {13{32'hFFFF_FFFF}}, 1'b1, 8'h99, 1'b1);
      expRegs = resetImage(); expPend = 1'b0; expNum = 8'h00; expLost = 1'b0;
      sbq.push_back({expRegs, expPend, expNum, expLost});
      @(posedge clk); #1;
      e = sbq.pop_front(); o = {busIf.rdata, busIf.irq_pending, busIf.irq_num, busIf.irq_lost};
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL reset_mid: got %h want %h", o, e); end
   endtask

   initial begin
      applyStimulus(1'b1, 13'h0000, '0, 1'b0, 8'h00, 1'b0);
      test_reset();
      test_write();
      test_irq_basic();
      test_irq_lost();
      test_handover();
      test_concurrent();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
